// File: rtl/jk_drive_sequencer.sv
// jk_drive_sequencer: queues target Q bits and drives J/K of an external JK flip-flop,
// one target per DRIVE/CHECK pair. Optional macro JK_CHECK_EN enables the CHECK comparison.
`default_nettype none

module jk_drive_sequencer #(
    parameter int DEPTH   = 4,
    parameter int DC_FILL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    input  logic       q_fb,
    input  logic       clr_err,
    output logic       J,
    output logic       K,
    output logic       drive_valid,
    output logic       busy,
    output logic       err,
    output logic [7:0] err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    logic            head;
    logic            raw_j;
    logic            raw_k;

    // Ready comes from registered occupancy only; a pop in the same cycle does not free a slot.
    assign in_ready = (count != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign pop      = (state == CHECK);
    assign head     = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_bit;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An incoming push starts DRIVE on the very next cycle; the entry is already written by then.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = ((count != '0) || push) ? DRIVE : IDLE;
            DRIVE:   state_next = CHECK;
            CHECK:   state_next = (count_next != '0) ? DRIVE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    generate
        if (DC_FILL == 0) begin : g_dc_setreset
            assign raw_j = ~q_fb & head;
            assign raw_k = q_fb & ~head;
        end else begin : g_dc_toggle
            assign raw_j = q_fb | head;
            assign raw_k = ~(q_fb & head);
        end
    endgenerate

    assign drive_valid = (state == DRIVE);
    assign J           = drive_valid & raw_j;
    assign K           = drive_valid & raw_k;
    assign busy        = (state != IDLE) || (count != '0);

`ifdef JK_CHECK_EN
    logic mismatch;
    assign mismatch = (state == CHECK) && (q_fb != head);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (clr_err) begin
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign err            = 1'b0;
    assign err_count      = 8'd0;
`endif

endmodule

`default_nettype wire

// File: doc/jk_drive_sequencer.md
JK_DRIVE_SEQUENCER -- requirements
Module: jk_drive_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, target FIFO entries (power of two, 2..16).
REQ-002 Parameter DC_FILL, default 0, don't-care fill policy: 0 = set/reset style, 1 = toggle style.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  target bit offered.
REQ-007 in_bit  input  1  desired next Q of the driven JK flip-flop.
REQ-008 in_ready  output  1  FIFO can accept; equals !full.
REQ-009 q_fb  input  1  Q fed back from the driven JK flip-flop.
REQ-010 clr_err  input  1  synchronous clear of err and err_count.
REQ-011 J  output  1  J drive to flip-flop.
REQ-012 K  output  1  K drive to flip-flop.
REQ-013 drive_valid  output  1  J/K are meaningful this cycle.
REQ-014 busy  output  1  FSM not in IDLE or FIFO non-empty.
REQ-015 err  output  1  sticky mismatch flag.
REQ-016 err_count  output  8  saturating mismatch count.

Function
REQ-017 A push SHALL occur on a rising clk edge when in_valid and in_ready are both 1; in_ready SHALL be computed from registered occupancy only (no same-cycle pass-through when full).
REQ-018 The FSM SHALL have states IDLE, DRIVE, CHECK; IDLE->DRIVE when FIFO non-empty; DRIVE->CHECK unconditionally; CHECK pops the head, then ->DRIVE if entries remain after the pop, else ->IDLE.
REQ-019 Each target SHALL occupy exactly 2 cycles (DRIVE then CHECK); back-to-back targets SHALL be issued with no idle cycle.
REQ-020 In DRIVE, drive_valid=1 and J/K SHALL be a combinational function of q_fb and the head target.
REQ-021 With DC_FILL=0: 0->0 gives J0 K0; 0->1 gives J1 K0; 1->0 gives J0 K1; 1->1 gives J0 K0.
REQ-022 With DC_FILL=1: 0->0 gives J0 K1; 0->1 gives J1 K1; 1->0 gives J1 K1; 1->1 gives J1 K0.
REQ-023 Outside DRIVE, J=0, K=0 and drive_valid=0 (flip-flop holds).
REQ-024 In CHECK, q_fb SHALL be compared with the head target; on mismatch, err is set and err_count increments, saturating at 255.
REQ-025 A simultaneous push and pop SHALL both take effect and leave occupancy unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-026 clr_err SHALL take priority over a same-cycle mismatch (result: err=0, err_count=0).
REQ-027 Pushes with in_ready=0 SHALL be ignored and SHALL NOT corrupt the FIFO.

Reset
REQ-028 Reset SHALL force the FSM to IDLE, empty the FIFO, and set J=0, K=0, drive_valid=0, busy=0, err=0, err_count=0, in_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard all queued targets immediately, without completing the current CHECK.

Configuration
REQ-030 Macro JK_CHECK_EN defined: the CHECK comparison, err and err_count SHALL behave as in REQ-024/026.
REQ-031 Macro JK_CHECK_EN undefined: the CHECK state and 2-cycle timing SHALL be retained; err and err_count SHALL be tied to 0 and clr_err ignored.

Verification
REQ-032 Reset, q_fb held 0, push 1 -> next cycle DRIVE with J=1 K=0 (DC_FILL=0), then CHECK, then IDLE; busy high for 2 cycles.
REQ-033 Model a JK flip-flop on J/K/q_fb and push 1,1,0,0,1 -> five DRIVE/CHECK pairs with no gaps, err=0, modelled Q sequence 1,1,0,0,1; repeat with DC_FILL=1 and identical Q result.
REQ-034 Hold off pops and push DEPTH+1 items -> in_ready=0 after the 4th push, the 5th is ignored, and exactly 4 targets are driven.
REQ-035 Tie q_fb=0 and push 1 three times -> err=1 and err_count=3; assert clr_err in the same cycle as a mismatch -> err=0, err_count=0.
REQ-036 Assert reset during the DRIVE of the 2nd of 3 queued targets -> J=K=0, in_ready=1, busy=0 immediately, and no further drive_valid.
REQ-037 Build without JK_CHECK_EN, tie q_fb=0 and push 1 -> identical J/K timing, err=0 and err_count=0.
